// File: rtl/coeff_int_to_frac_if.sv
// Handshake bundle between the RLE decoder, the coefficient expander and the IDCT.
// Carries the integer coefficient stream in and the eight parallel Q13.6 buses out.
interface coeff_int_to_frac_if #(
  parameter int INT_W     = 13,
  parameter int FRAC_BITS = 6
);
  localparam int OUT_W = INT_W + FRAC_BITS;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [INT_W-1:0] in_coeff;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] fraction_z0;
  logic signed [OUT_W-1:0] fraction_z1;
  logic signed [OUT_W-1:0] fraction_z2;
  logic signed [OUT_W-1:0] fraction_z3;
  logic signed [OUT_W-1:0] fraction_z4;
  logic signed [OUT_W-1:0] fraction_z5;
  logic signed [OUT_W-1:0] fraction_z6;
  logic signed [OUT_W-1:0] fraction_z7;
  logic                    err;

  modport slave (
    input  in_valid, in_coeff, in_last, out_ready,
    output in_ready, out_valid, err,
    output fraction_z0, fraction_z1, fraction_z2, fraction_z3,
    output fraction_z4, fraction_z5, fraction_z6, fraction_z7
  );

  modport master (
    output in_valid, in_coeff, in_last, out_ready,
    input  in_ready, out_valid, err,
    input  fraction_z0, fraction_z1, fraction_z2, fraction_z3,
    input  fraction_z4, fraction_z5, fraction_z6, fraction_z7
  );
endinterface

// File: rtl/coeff_int_to_frac.sv
// Expands 13-bit integer DCT coefficients to Q13.6 and assembles blocks of eight for the IDCT.
// A shadow bank collects the next block while the output bank is held under back-pressure.
module coeff_int_to_frac #(
  parameter int INT_W      = 13,
  parameter int FRAC_BITS  = 6,
  parameter int ROUND_HALF = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  coeff_int_to_frac_if.slave bus
);
  localparam int OUT_W = INT_W + FRAC_BITS;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  // Midpoint reconstruction is an OR into bit FRAC_BITS-1; zero stays exactly zero.
  function automatic logic signed [OUT_W-1:0] expand(input logic signed [INT_W-1:0] c);
    logic signed [OUT_W-1:0] f;
    f = {c, {FRAC_BITS{1'b0}}};
    if (ROUND_HALF != 0 && c != '0) f[FRAC_BITS-1] = 1'b1;
    return f;
  endfunction

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    err_q, err_d;
  logic signed [OUT_W-1:0] shadow_q [8];
  logic signed [OUT_W-1:0] obank_q  [8];
  logic signed [OUT_W-1:0] frac;
  logic                    in_ready, xfer, drain;
  logic                    shadow_we, ld_block, ld_shadow;

  assign frac     = expand(bus.in_coeff);
  assign in_ready = (state_q == COLLECT);
  assign xfer     = bus.in_valid && in_ready;
  assign drain    = out_valid_q && bus.out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;
    shadow_we   = 1'b0;
    ld_block    = 1'b0;
    ld_shadow   = 1'b0;
    if (drain) out_valid_d = 1'b0;
    case (state_q)
      COLLECT: begin
        if (xfer) begin
          shadow_we = 1'b1;
          if (cnt_q != 3'd7 && !bus.in_last) begin
            cnt_d = cnt_q + 3'd1;
          end else if (cnt_q != 3'd7 || !bus.in_last) begin
            err_d = 1'b1;
            cnt_d = 3'd0;
          end else begin
            cnt_d = 3'd0;
            if (!out_valid_q || drain) begin
              ld_block    = 1'b1;
              out_valid_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        // out_valid is always set here, so out_ready alone frees the output bank.
        if (bus.out_ready) begin
          ld_shadow   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= 3'd0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[cnt_q] <= frac;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) obank_q[i] <= '0;
    end else if (ld_block) begin
      for (int i = 0; i < 7; i++) obank_q[i] <= shadow_q[i];
      obank_q[7] <= frac;
    end else if (ld_shadow) begin
      for (int i = 0; i < 8; i++) obank_q[i] <= shadow_q[i];
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.err         = err_q;
  assign bus.fraction_z0 = obank_q[0];
  assign bus.fraction_z1 = obank_q[1];
  assign bus.fraction_z2 = obank_q[2];
  assign bus.fraction_z3 = obank_q[3];
  assign bus.fraction_z4 = obank_q[4];
  assign bus.fraction_z5 = obank_q[5];
  assign bus.fraction_z6 = obank_q[6];
  assign bus.fraction_z7 = obank_q[7];
endmodule

// File: tb/tb_coeff_int_to_frac.sv
// Bench for coeff_int_to_frac: two instances (plain and midpoint-rounded) driven in lockstep
// and checked against a transaction-level model of block assembly and framing.
module tb_coeff_int_to_frac;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  coeff_int_to_frac_if #(.INT_W(13), .FRAC_BITS(6)) if0 ();
  coeff_int_to_frac_if #(.INT_W(13), .FRAC_BITS(6)) if1 ();

  assign if1.in_valid  = if0.in_valid;
  assign if1.in_coeff  = if0.in_coeff;
  assign if1.in_last   = if0.in_last;
  assign if1.out_ready = if0.out_ready;

  coeff_int_to_frac #(.INT_W(13), .FRAC_BITS(6), .ROUND_HALF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0));
  coeff_int_to_frac #(.INT_W(13), .FRAC_BITS(6), .ROUND_HALF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1));

  logic [151:0] z0, z1;
  assign z0 = {if0.fraction_z7, if0.fraction_z6, if0.fraction_z5, if0.fraction_z4,
               if0.fraction_z3, if0.fraction_z2, if0.fraction_z1, if0.fraction_z0};
  assign z1 = {if1.fraction_z7, if1.fraction_z6, if1.fraction_z5, if1.fraction_z4,
               if1.fraction_z3, if1.fraction_z2, if1.fraction_z1, if1.fraction_z0};

  int tests = 0;
  int fails = 0;
  int ov_cnt = 0;
  int err_cnt = 0;
  bit known = 1'b0;
  bit err_exp = 1'b0;
  int cur[$];
  logic [151:0] exp0[$];
  logic [151:0] exp1[$];

  task automatic chk(input string tag, input logic [151:0] got, input logic [151:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Reference: each coefficient scaled by 64, plus half an LSB step for non-zero values when rounding.
  function automatic logic [151:0] model_blk(input int c[$], input bit rh);
    logic [151:0] b;
    int v;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      v = c[i] * 64;
      if (rh && c[i] != 0) v = v + 32;
      b[i*19 +: 19] = v[18:0];
    end
    return b;
  endfunction

  function automatic logic [151:0] pack_vals(input int v[8]);
    logic [151:0] b;
    b = '0;
    for (int i = 0; i < 8; i++) b[i*19 +: 19] = v[i][18:0];
    return b;
  endfunction

  task automatic tick(output bit acc);
    int c;
    @(negedge clk);
    acc = 1'b0;
    if (known) begin
      chk("err0", if0.err, err_exp);
      chk("err1", if1.err, err_exp);
      chk("ov_match", if1.out_valid, if0.out_valid);
      if (if0.err) err_cnt++;
      if (if0.out_valid) begin
        ov_cnt++;
        chk("blk_expected", exp0.size() > 0, 1);
        if (exp0.size() > 0) begin
          chk("blk0", z0, exp0[0]);
          chk("blk1", z1, exp1[0]);
        end
      end
    end
    if (!rst_n) begin
      cur.delete();
      exp0.delete();
      exp1.delete();
      err_exp = 1'b0;
      known = 1'b1;
    end else begin
      err_exp = 1'b0;
      if (if0.out_valid && if0.out_ready && exp0.size() > 0) begin
        void'(exp0.pop_front());
        void'(exp1.pop_front());
      end
      if (if0.in_valid && if0.in_ready) begin
        acc = 1'b1;
        c = int'($signed(if0.in_coeff));
        cur.push_back(c);
        if (if0.in_last && cur.size() == 8) begin
          exp0.push_back(model_blk(cur, 1'b0));
          exp1.push_back(model_blk(cur, 1'b1));
          cur.delete();
        end else if (if0.in_last || cur.size() == 8) begin
          err_exp = 1'b1;
          cur.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit acc;
    if0.in_valid = 1'b0;
    if0.in_last  = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(input int c, input bit last);
    bit acc;
    int n;
    if0.in_valid = 1'b1;
    if0.in_coeff = 13'(c);
    if0.in_last  = last;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 64) begin
      tick(acc);
      n++;
    end
    chk("accept", acc, 1);
    if0.in_valid = 1'b0;
    if0.in_last  = 1'b0;
  endtask

  task automatic send_rand_block();
    int c;
    for (int i = 0; i < 8; i++) begin
      c = int'($urandom_range(0, 8191)) - 4096;
      send(c, i == 7);
    end
  endtask

  initial begin
    int s[8];
    int e0[8];
    int e1[8];
    int ov0, er0;
    bit acc;
    s  = '{1, -1, 0, 4095, -4096, 2, -2, 100};
    e0 = '{64, -64, 0, 262080, -262144, 128, -128, 6400};
    e1 = '{96, -32, 0, 262112, -262112, 160, -96, 6432};

    rst_n = 1'b0;
    if0.in_valid = 1'b0;
    if0.in_coeff = '0;
    if0.in_last = 1'b0;
    if0.out_ready = 1'b1;
    tick(acc);
    rst_n = 1'b1;
    chk("rst_ov", if0.out_valid, 0);
    chk("rst_err", if0.err, 0);
    chk("rst_z0", z0, 0);
    chk("rst_z1", z1, 0);
    chk("rst_rdy", if0.in_ready, 1);

    // Single directed block, both rounding modes.
    ov0 = ov_cnt;
    for (int i = 0; i < 8; i++) send(s[i], i == 7);
    chk("single_ov", if0.out_valid, 1);
    chk("single_z0", z0, pack_vals(e0));
    chk("single_z1", z1, pack_vals(e1));
    idle(1);
    chk("single_ov_drop", if0.out_valid, 0);
    chk("single_ov_len", ov_cnt - ov0, 1);

    // Back-pressure: two blocks with the IDCT stalled.
    if0.out_ready = 1'b0;
    send_rand_block();
    chk("bp_ov1", if0.out_valid, 1);
    send_rand_block();
    chk("bp_hold_rdy", if0.in_ready, 0);
    idle(2);
    chk("bp_hold_rdy2", if0.in_ready, 0);
    chk("bp_hold_ov", if0.out_valid, 1);
    if0.out_ready = 1'b1;
    idle(1);
    if0.out_ready = 1'b0;
    chk("bp_blk2_ov", if0.out_valid, 1);
    chk("bp_rdy_back", if0.in_ready, 1);
    idle(1);
    if0.out_ready = 1'b1;
    idle(1);
    chk("bp_drained", if0.out_valid, 0);

    // Continuous streaming of four blocks.
    ov0 = ov_cnt;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        chk("stream_rdy", if0.in_ready, 1);
        send(int'($urandom_range(0, 8191)) - 4096, i == 7);
      end
    end
    idle(1);
    chk("stream_ov_cnt", ov_cnt - ov0, 4);

    // Early in_last on the fifth coefficient.
    ov0 = ov_cnt;
    er0 = err_cnt;
    for (int i = 0; i < 5; i++) send(i * 7 - 11, i == 4);
    idle(2);
    chk("early_err", err_cnt - er0, 1);
    chk("early_no_ov", ov_cnt - ov0, 0);
    send_rand_block();
    idle(1);
    chk("early_recover", ov_cnt - ov0, 1);

    // Missing in_last on the eighth coefficient.
    ov0 = ov_cnt;
    er0 = err_cnt;
    for (int i = 0; i < 8; i++) send(i - 4, 1'b0);
    idle(2);
    chk("late_err", err_cnt - er0, 1);
    chk("late_no_ov", ov_cnt - ov0, 0);

    // Reset in the middle of a block.
    for (int i = 0; i < 3; i++) send(500 + i, 1'b0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk("mid_rst_ov", if0.out_valid, 0);
    chk("mid_rst_z0", z0, 0);
    chk("mid_rst_z1", z1, 0);
    chk("mid_rst_rdy", if0.in_ready, 1);
    ov0 = ov_cnt;
    send_rand_block();
    idle(1);
    chk("mid_rst_blk", ov_cnt - ov0, 1);
    chk("queue_empty", exp0.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
